// File: rtl/saradc_dig_scan_seq.sv
// Multi-channel SAR scan sequencer: mask-driven channel stepping, oversampled accumulation and
// valid/ready result delivery. Define SARADC_DIG_OVS_AVG_EN to return rounded averages.
module saradc_dig_scan_seq #(
    parameter int unsigned N_CHANNELS   = 16,
    parameter int unsigned N_CONV_BITS  = 11,
    parameter int unsigned TRACK_W      = 4,
    parameter int unsigned MAX_OVS_LOG2 = 3
) (
    input  logic                                  clk,
    input  logic                                  nres,
    input  logic                                  enable_i,
    input  logic                                  start_i,
    input  logic                                  cont_i,
    input  logic [N_CHANNELS-1:0]                 ch_mask_i,
    input  logic [$clog2(MAX_OVS_LOG2+1)-1:0]     ovs_log2_i,
    input  logic [TRACK_W-1:0]                    track_len_i,
    input  logic                                  comp_i,
    input  logic                                  result_ready_i,
    output logic [$clog2(N_CHANNELS)-1:0]         sample_ch_o,
    output logic                                  track_o,
    output logic                                  sar_clk_enable_o,
    output logic [N_CONV_BITS-1:0]                dac_code_o,
    output logic [N_CONV_BITS+MAX_OVS_LOG2-1:0]   result_o,
    output logic [$clog2(N_CHANNELS)-1:0]         result_ch_o,
    output logic                                  result_valid_o,
    output logic                                  eos_o,
    output logic                                  busy_o
);
    localparam int unsigned CH_W  = $clog2(N_CHANNELS);
    localparam int unsigned OVS_W = $clog2(MAX_OVS_LOG2 + 1);
    localparam int unsigned RES_W = N_CONV_BITS + MAX_OVS_LOG2;
    localparam int unsigned CNT_W = MAX_OVS_LOG2 + 1;

    typedef enum logic [2:0] {StIdle, StSelect, StTrack, StConv, StAccum, StOut} state_e;

    state_e                 state_q, state_d;
    logic [N_CHANNELS-1:0]  mask_q, mask_d;
    logic [OVS_W-1:0]       ovs_q, ovs_d;
    logic [TRACK_W-1:0]     track_len_q, track_len_d;
    logic [TRACK_W-1:0]     track_cnt_q, track_cnt_d;
    logic [CH_W-1:0]        ptr_q, ptr_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [CH_W-1:0]        result_ch_q, result_ch_d;
    logic [N_CONV_BITS-1:0] code_q, code_d;
    logic [N_CONV_BITS-1:0] trial_q, trial_d;
    logic [RES_W-1:0]       acc_q, acc_d;
    logic [RES_W-1:0]       result_q, result_d;
    logic [CNT_W-1:0]       smp_cnt_q, smp_cnt_d;

    logic [CH_W-1:0]  next_ch;
    logic             has_above;
    logic             smp_last;
    logic [OVS_W-1:0] ovs_clamped;
    logic [RES_W-1:0] acc_sum;
    logic [RES_W-1:0] res_val;

    always_comb begin
        next_ch   = '0;
        has_above = 1'b0;
        // Downward sweep so the lowest qualifying index is the one that sticks.
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (mask_q[i] && (CH_W'(i) >= ptr_q)) next_ch = CH_W'(i);
        end
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (mask_q[i] && (CH_W'(i) > ch_q)) has_above = 1'b1;
        end
    end

    assign ovs_clamped = (32'(ovs_log2_i) > MAX_OVS_LOG2) ? OVS_W'(MAX_OVS_LOG2) : ovs_log2_i;
    assign smp_last    = (smp_cnt_q == ((CNT_W'(1) << ovs_q) - CNT_W'(1)));
    assign acc_sum     = acc_q + RES_W'(code_q);

`ifdef SARADC_DIG_OVS_AVG_EN
    localparam int unsigned SUM_W = RES_W + 1;
    localparam logic [SUM_W-1:0] SAT = SUM_W'((1 << N_CONV_BITS) - 1);
    logic [SUM_W-1:0] rounded;

    always_comb begin
        rounded = '0;
        res_val = acc_sum;
        if (ovs_q != '0) begin
            rounded = ({1'b0, acc_sum} + (SUM_W'(1) << (ovs_q - 1'b1))) >> ovs_q;
            res_val = (rounded > SAT) ? RES_W'(SAT) : RES_W'(rounded);
        end
    end
`else
    assign res_val = acc_sum;
`endif

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ovs_d       = ovs_q;
        track_len_d = track_len_q;
        track_cnt_d = track_cnt_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        result_ch_d = result_ch_q;
        code_d      = code_q;
        trial_d     = trial_q;
        acc_d       = acc_q;
        result_d    = result_q;
        smp_cnt_d   = smp_cnt_q;
        eos_o       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && (|ch_mask_i)) begin
                    mask_d      = ch_mask_i;
                    ovs_d       = ovs_clamped;
                    track_len_d = track_len_i;
                    ptr_d       = '0;
                    state_d     = StSelect;
                end
            end
            StSelect: begin
                ch_d        = next_ch;
                acc_d       = '0;
                smp_cnt_d   = '0;
                track_cnt_d = '0;
                state_d     = StTrack;
            end
            StTrack: begin
                if (track_cnt_q == track_len_q) begin
                    // First trial bit is presented in the very first CONV cycle.
                    code_d  = {1'b1, {(N_CONV_BITS-1){1'b0}}};
                    trial_d = {1'b1, {(N_CONV_BITS-1){1'b0}}};
                    state_d = StConv;
                end else begin
                    track_cnt_d = track_cnt_q + 1'b1;
                end
            end
            StConv: begin
                code_d  = (comp_i ? code_q : (code_q & ~trial_q)) | (trial_q >> 1);
                trial_d = trial_q >> 1;
                if (trial_q[0]) state_d = StAccum;
            end
            StAccum: begin
                acc_d = acc_sum;
                if (smp_last) begin
                    result_d    = res_val;
                    result_ch_d = ch_q;
                    state_d     = StOut;
                end else begin
                    smp_cnt_d   = smp_cnt_q + 1'b1;
                    track_cnt_d = '0;
                    state_d     = StTrack;
                end
            end
            StOut: begin
                if (result_ready_i) begin
                    if (has_above) begin
                        ptr_d   = ch_q + 1'b1;
                        state_d = StSelect;
                    end else begin
                        eos_o = 1'b1;
                        ptr_d = '0;
                        state_d = cont_i ? StSelect : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Losing enable abandons the scan, including any unconsumed result.
        if (!enable_i) begin
            state_d     = StIdle;
            mask_d      = '0;
            ovs_d       = '0;
            track_len_d = '0;
            track_cnt_d = '0;
            ptr_d       = '0;
            ch_d        = '0;
            result_ch_d = '0;
            code_d      = '0;
            trial_d     = '0;
            acc_d       = '0;
            result_d    = '0;
            smp_cnt_d   = '0;
            eos_o       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nres) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            ovs_q       <= '0;
            track_len_q <= '0;
            track_cnt_q <= '0;
            ptr_q       <= '0;
            ch_q        <= '0;
            result_ch_q <= '0;
            code_q      <= '0;
            trial_q     <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            smp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ovs_q       <= ovs_d;
            track_len_q <= track_len_d;
            track_cnt_q <= track_cnt_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            result_ch_q <= result_ch_d;
            code_q      <= code_d;
            trial_q     <= trial_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            smp_cnt_q   <= smp_cnt_d;
        end
    end

    assign sample_ch_o      = ch_q;
    assign track_o          = (state_q == StTrack);
    assign sar_clk_enable_o = (state_q == StConv);
    assign dac_code_o       = code_q;
    assign result_o         = result_q;
    assign result_ch_o      = result_ch_q;
    assign result_valid_o   = (state_q == StOut);
    assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_saradc_dig_scan_seq.sv
// Bench for saradc_dig_scan_seq: ideal comparator against a per-channel/per-sample input table,
// expected results computed from the scan rules with plain arithmetic.
module tb_saradc_dig_scan_seq;
    localparam int NB = 11;

    logic        clk = 1'b0;
    logic        nres = 1'b0;
    logic        enable_i = 1'b0;
    logic        start_i = 1'b0;
    logic        cont_i = 1'b0;
    logic [15:0] ch_mask_i = '0;
    logic [1:0]  ovs_log2_i = '0;
    logic [3:0]  track_len_i = '0;
    logic        comp_i;
    logic        result_ready_i = 1'b0;
    logic [3:0]  sample_ch_o;
    logic        track_o;
    logic        sar_clk_enable_o;
    logic [10:0] dac_code_o;
    logic [13:0] result_o;
    logic [3:0]  result_ch_o;
    logic        result_valid_o;
    logic        eos_o;
    logic        busy_o;

    logic [10:0] vin_tab [16][8];
    int          smp_idx = 0;
    logic        conv_prev = 1'b0;
    int          eos_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    saradc_dig_scan_seq dut (
        .clk              (clk),
        .nres             (nres),
        .enable_i         (enable_i),
        .start_i          (start_i),
        .cont_i           (cont_i),
        .ch_mask_i        (ch_mask_i),
        .ovs_log2_i       (ovs_log2_i),
        .track_len_i      (track_len_i),
        .comp_i           (comp_i),
        .result_ready_i   (result_ready_i),
        .sample_ch_o      (sample_ch_o),
        .track_o          (track_o),
        .sar_clk_enable_o (sar_clk_enable_o),
        .dac_code_o       (dac_code_o),
        .result_o         (result_o),
        .result_ch_o      (result_ch_o),
        .result_valid_o   (result_valid_o),
        .eos_o            (eos_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    // Ideal comparator: input voltage of the current channel and sample number.
    assign comp_i = (vin_tab[sample_ch_o][smp_idx & 7] >= dac_code_o);

    always @(negedge clk) begin
        if (!busy_o || result_valid_o) smp_idx <= 0;
        else if (conv_prev && !sar_clk_enable_o) smp_idx <= smp_idx + 1;
        conv_prev <= sar_clk_enable_o;
        if (eos_o) eos_cnt <= eos_cnt + 1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

    function automatic logic [13:0] exp_result(input int ch, input int ovs);
        int sum;
        sum = 0;
        for (int s = 0; s < (1 << ovs); s++) sum += int'(vin_tab[ch][s]);
`ifdef SARADC_DIG_OVS_AVG_EN
        if (ovs > 0) begin
            sum = (sum + (1 << (ovs - 1))) / (1 << ovs);
            if (sum > 2047) sum = 2047;
        end
`endif
        return 14'(sum);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_vin();
        for (int c = 0; c < 16; c++)
            for (int s = 0; s < 8; s++) vin_tab[c][s] = 11'($urandom_range(0, 2047));
    endtask

    // Pulses start, then scrambles the configuration inputs to prove they were latched.
    task automatic start_scan(input logic [15:0] mask, input int ovs, input int tl, input bit cont);
        ch_mask_i   = mask;
        ovs_log2_i  = 2'(ovs);
        track_len_i = 4'(tl);
        cont_i      = cont;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        ch_mask_i   = 16'($urandom);
        ovs_log2_i  = 2'($urandom);
        track_len_i = 4'($urandom);
    endtask

    task automatic wait_valid(input int budget, output int cycles, output int trk, output int cnv,
                              output logic [10:0] first_dac, output bit ok);
        bit seen_conv;
        seen_conv = 1'b0;
        cycles = 0;
        trk = 0;
        cnv = 0;
        first_dac = '0;
        ok = 1'b0;
        while (!ok && cycles < budget) begin
            tick();
            cycles++;
            if (track_o) trk++;
            if (sar_clk_enable_o) begin
                if (!seen_conv) first_dac = dac_code_o;
                seen_conv = 1'b1;
                cnv++;
            end
            if (result_valid_o) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        nres = 1'b0;
        enable_i = 1'b1;
        start_i = 1'b1;
        ch_mask_i = 16'hFFFF;
        repeat (3) tick();
        checks++;
        if ({busy_o, track_o, sar_clk_enable_o, result_valid_o, eos_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/track/sar/valid/eos=%b want 00000",
                     {busy_o, track_o, sar_clk_enable_o, result_valid_o, eos_o});
        end
        checks++;
        if (dac_code_o !== '0 || result_o !== '0 || result_ch_o !== '0 || sample_ch_o !== '0) begin
            errors++;
            $display("FAIL reset_data: dac=%h result=%h rch=%0d sch=%0d want all 0",
                     dac_code_o, result_o, result_ch_o, sample_ch_o);
        end
        start_i = 1'b0;
        nres = 1'b1;
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_single();
        int cyc, trk, cnv, eos0;
        logic [10:0] fd;
        bit ok;
        vin_tab[0][0] = 11'h2AB;
        result_ready_i = 1'b1;
        eos0 = eos_cnt;
        start_scan(16'h0001, 0, 2, 1'b0);
        wait_valid(100, cyc, trk, cnv, fd, ok);
        checks++;
        if (!ok || cyc != 16) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles (valid=%0b) want 16", cyc, ok);
        end
        checks++;
        if (trk != 3 || cnv != 11) begin
            errors++;
            $display("FAIL single_phases: track=%0d conv=%0d want 3 and 11", trk, cnv);
        end
        checks++;
        if (fd !== 11'h400) begin
            errors++;
            $display("FAIL single_first_dac: got %h want 400", fd);
        end
        checks++;
        if (result_o !== 14'h2AB || result_ch_o !== 4'd0) begin
            errors++;
            $display("FAIL single_result: got %h ch %0d want 2ab ch 0", result_o, result_ch_o);
        end
        checks++;
        if (eos_o !== 1'b1) begin
            errors++;
            $display("FAIL single_eos: got %b want 1", eos_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || result_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b valid=%b want 0 0", busy_o, result_valid_o);
        end
        tick();
        checks++;
        if (eos_cnt - eos0 != 1) begin
            errors++;
            $display("FAIL single_eos_count: got %0d pulses want 1", eos_cnt - eos0);
        end
    endtask

    task automatic run_scan(input logic [15:0] mask, input int ovs, input int tl);
        int lat, cyc, trk, cnv, eos0;
        logic [10:0] fd;
        bit ok;
        int exp_ch[$];
        for (int i = 0; i < 16; i++) if (mask[i]) exp_ch.push_back(i);
        lat = 1 + (1 << ovs) * (tl + 1 + NB + 1);
        randomize_vin();
        result_ready_i = 1'b1;
        eos0 = eos_cnt;
        start_scan(mask, ovs, tl, 1'b0);
        foreach (exp_ch[k]) begin
            wait_valid(lat + 10, cyc, trk, cnv, fd, ok);
            checks++;
            if (!ok || cyc != ((k == 0) ? lat : lat + 1)) begin
                errors++;
                $display("FAIL scan_latency: mask %h item %0d got %0d cycles (valid=%0b) want %0d",
                         mask, k, cyc, ok, (k == 0) ? lat : lat + 1);
            end
            checks++;
            if (trk != (1 << ovs) * (tl + 1) || cnv != (1 << ovs) * NB) begin
                errors++;
                $display("FAIL scan_phases: track=%0d conv=%0d want %0d and %0d",
                         trk, cnv, (1 << ovs) * (tl + 1), (1 << ovs) * NB);
            end
            checks++;
            if (result_ch_o !== 4'(exp_ch[k]) || result_o !== exp_result(exp_ch[k], ovs)) begin
                errors++;
                $display("FAIL scan_result: got ch %0d val %0d want ch %0d val %0d",
                         result_ch_o, result_o, exp_ch[k], exp_result(exp_ch[k], ovs));
            end
            checks++;
            if (eos_o !== (k == exp_ch.size() - 1)) begin
                errors++;
                $display("FAIL scan_eos: item %0d got %b want %b", k, eos_o,
                         (k == exp_ch.size() - 1));
            end
            if (!ok) break;
        end
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b0 || eos_cnt - eos0 != 1) begin
            errors++;
            $display("FAIL scan_end: busy=%b eos pulses=%0d want 0 and 1", busy_o, eos_cnt - eos0);
        end
    endtask

    task automatic test_scan_order();
        run_scan(16'h8421, 1, 2);
    endtask

    task automatic test_random_scans();
        logic [15:0] m;
        for (int n = 0; n < 3; n++) begin
            m = 16'($urandom) & 16'($urandom);
            m[$urandom_range(0, 15)] = 1'b1;
            run_scan(m, $urandom_range(0, 3), $urandom_range(0, 15));
        end
    endtask

    task automatic test_ovs_avg();
        int cyc, trk, cnv;
        logic [10:0] fd;
        bit ok;
        logic [13:0] exp_v;
        for (int s = 0; s < 8; s++) vin_tab[3][s] = (s % 2 == 1) ? 11'd101 : 11'd100;
`ifdef SARADC_DIG_OVS_AVG_EN
        exp_v = 14'd101;
`else
        exp_v = 14'd402;
`endif
        result_ready_i = 1'b1;
        start_scan(16'h0008, 2, 1, 1'b0);
        wait_valid(200, cyc, trk, cnv, fd, ok);
        checks++;
        if (!ok || result_o !== exp_v || result_ch_o !== 4'd3) begin
            errors++;
            $display("FAIL ovs4_result: got %0d ch %0d (valid=%0b) want %0d ch 3",
                     result_o, result_ch_o, ok, exp_v);
        end
        tick();
        for (int s = 0; s < 8; s++) vin_tab[3][s] = 11'(2047 - s);
        start_scan(16'h0008, 3, 0, 1'b0);
        wait_valid(300, cyc, trk, cnv, fd, ok);
        checks++;
        if (!ok || result_o !== exp_result(3, 3) || cnv != 8 * NB) begin
            errors++;
            $display("FAIL ovs8_result: got %0d conv %0d want %0d conv %0d",
                     result_o, cnv, exp_result(3, 3), 8 * NB);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc, trk, cnv;
        logic [10:0] fd;
        bit ok;
        randomize_vin();
        result_ready_i = 1'b0;
        start_scan(16'h0012, 0, 1, 1'b0);
        wait_valid(100, cyc, trk, cnv, fd, ok);
        checks++;
        if (!ok || result_ch_o !== 4'd1 || result_o !== exp_result(1, 0)) begin
            errors++;
            $display("FAIL bp_first: got ch %0d val %0d want ch 1 val %0d",
                     result_ch_o, result_o, exp_result(1, 0));
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (result_valid_o !== 1'b1 || result_o !== exp_result(1, 0) || result_ch_o !== 4'd1 ||
                track_o !== 1'b0 || sar_clk_enable_o !== 1'b0 || eos_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b val=%0d ch=%0d trk=%b want 1 %0d 1 0",
                         i, result_valid_o, result_o, result_ch_o, track_o, exp_result(1, 0));
            end
        end
        result_ready_i = 1'b1;
        tick();
        checks++;
        if (result_valid_o !== 1'b0 || busy_o !== 1'b1 || track_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_select: valid=%b busy=%b track=%b want 0 1 0",
                     result_valid_o, busy_o, track_o);
        end
        tick();
        checks++;
        if (track_o !== 1'b1 || sample_ch_o !== 4'd4) begin
            errors++;
            $display("FAIL bp_next_track: track=%b ch=%0d want 1 ch 4", track_o, sample_ch_o);
        end
        wait_valid(100, cyc, trk, cnv, fd, ok);
        checks++;
        if (!ok || result_ch_o !== 4'd4 || result_o !== exp_result(4, 0) || eos_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: got ch %0d val %0d eos %b want ch 4 val %0d eos 1",
                     result_ch_o, result_o, eos_o, exp_result(4, 0));
        end
        tick();
    endtask

    task automatic test_cont();
        int cyc, trk, cnv, eos0, lat;
        logic [10:0] fd;
        bit ok;
        lat = 1 + (0 + 1 + NB + 1);
        vin_tab[1][0] = 11'($urandom_range(0, 2047));
        result_ready_i = 1'b1;
        eos0 = eos_cnt;
        start_scan(16'h0002, 0, 0, 1'b1);
        for (int r = 0; r < 4; r++) begin
            wait_valid(lat + 10, cyc, trk, cnv, fd, ok);
            checks++;
            if (!ok || cyc != ((r == 0) ? lat : lat + 1) || result_ch_o !== 4'd1 ||
                result_o !== exp_result(1, 0) || eos_o !== 1'b1) begin
                errors++;
                $display("FAIL cont_round: r=%0d cyc=%0d ch=%0d val=%0d eos=%b want ch 1 val %0d eos 1",
                         r, cyc, result_ch_o, result_o, eos_o, exp_result(1, 0));
            end
            vin_tab[1][0] = 11'($urandom_range(0, 2047));
            if (r == 3) cont_i = 1'b0;
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop: busy=%b want 0", busy_o);
        end
        tick();
        checks++;
        if (eos_cnt - eos0 != 4) begin
            errors++;
            $display("FAIL cont_eos_count: got %0d want 4", eos_cnt - eos0);
        end
    endtask

    task automatic test_enable_drop();
        bit ok, seen;
        int eos0;
        randomize_vin();
        result_ready_i = 1'b1;
        eos0 = eos_cnt;
        start_scan(16'h0101, 0, 3, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            if (sar_clk_enable_o) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL en_reach_conv: sar_clk_enable never 1, want 1 within 60 cycles");
        end
        repeat (3) tick();
        enable_i = 1'b0;
        tick();
        checks++;
        if ({track_o, sar_clk_enable_o, busy_o, result_valid_o, eos_o} !== 5'b0 ||
            dac_code_o !== '0 || sample_ch_o !== '0) begin
            errors++;
            $display("FAIL en_drop_outputs: trk/sar/busy/valid/eos=%b dac=%h ch=%0d want all 0",
                     {track_o, sar_clk_enable_o, busy_o, result_valid_o, eos_o}, dac_code_o,
                     sample_ch_o);
        end
        enable_i = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (result_valid_o || busy_o) seen = 1'b1;
        end
        checks++;
        if (seen || eos_cnt != eos0) begin
            errors++;
            $display("FAIL en_no_result: activity=%b eos pulses=%0d want 0 0", seen, eos_cnt - eos0);
        end
        start_scan(16'h0300, 0, 5, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (track_o) ok = 1'b1;
        end
        tick();
        nres = 1'b0;
        tick();
        checks++;
        if (!ok || {track_o, sar_clk_enable_o, busy_o, result_valid_o, eos_o} !== 5'b0 ||
            dac_code_o !== '0) begin
            errors++;
            $display("FAIL rst_mid_track: reached=%b trk/sar/busy/valid/eos=%b dac=%h want 1 0 0",
                     ok, {track_o, sar_clk_enable_o, busy_o, result_valid_o, eos_o}, dac_code_o);
        end
        nres = 1'b1;
        tick();
        run_scan(16'h0003, 0, 1);
    endtask

    task automatic test_misc();
        int cyc, trk, cnv;
        logic [10:0] fd;
        bit ok;
        start_scan(16'h0000, 0, 0, 1'b0);
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_mask: busy=%b want 0", busy_o);
        end
        enable_i = 1'b0;
        start_scan(16'h00FF, 0, 0, 1'b0);
        enable_i = 1'b1;
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_disabled: busy=%b want 0", busy_o);
        end
        randomize_vin();
        result_ready_i = 1'b1;
        start_scan(16'h0010, 0, 0, 1'b0);
        repeat (4) tick();
        ch_mask_i = 16'hFFFF;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_valid(50, cyc, trk, cnv, fd, ok);
        checks++;
        if (!ok || result_ch_o !== 4'd4 || result_o !== exp_result(4, 0) || eos_o !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: ch %0d val %0d eos %b want ch 4 val %0d eos 1",
                     result_ch_o, result_o, eos_o, exp_result(4, 0));
        end
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_end: busy=%b want 0", busy_o);
        end
    endtask

    initial begin
        for (int c = 0; c < 16; c++)
            for (int s = 0; s < 8; s++) vin_tab[c][s] = '0;
        test_reset();
        test_single();
        test_scan_order();
        test_random_scans();
        test_ovs_avg();
        test_backpressure();
        test_cont();
        test_enable_drop();
        test_misc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
